page_param_loader: RTL and testbench

Upstream stage of the page-parameter RAM on the VSDSquadron FM design. It accepts a framed byte stream over a valid/ready handshake, parses the start index, length, payload and checksum, and writes the payload bytes into a 256×8 block-RAM page. A registered read port lets the downstream consumer fetch bytes from the page. Each frame ends with a one-cycle ok or error pulse.

---
 rtl/page_param_pkg.sv | 19 +
 rtl/page_ram.sv | 27 ++
 rtl/page_param_loader.sv | 95 +++++++++
 tb/tb_page_param_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_param_pkg.sv
// page_param_pkg: shared state type and page geometry for the page-parameter loader
package page_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM,
        DONE
    } loader_state_t;

    localparam int PAGE_DEPTH = 256;
    localparam int PAGE_AW    = 8;
    localparam int PAGE_DW    = 8;

    localparam logic [PAGE_DW-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/page_ram.sv
// page_ram: 256x8 simple dual-port page with registered read, read-before-write
module page_ram
    import page_param_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [PAGE_AW-1:0] wr_addr,
    input  logic [PAGE_DW-1:0] wr_data,
    input  logic [PAGE_AW-1:0] rd_addr,
    output logic [PAGE_DW-1:0] rd_data
);

    (* ram_style = "block" *) logic [PAGE_DW-1:0] mem [PAGE_DEPTH];

    // Array carries no reset so it maps onto a single block RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; a same-address write in this cycle is not yet visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/page_param_loader.sv
// page_param_loader: parses sync/addr/len/payload/checksum frames into the page RAM
module page_param_loader
    import page_param_pkg::*;
#(
    parameter logic [PAGE_DW-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic               hw_clk,
    input  logic               rst_n,
    input  logic [PAGE_DW-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PAGE_AW-1:0] rd_addr,
    output logic [PAGE_DW-1:0] rd_data,
    output logic               busy,
    output logic               frame_ok,
    output logic               frame_err,
    output logic [8:0]         wr_count
);

    loader_state_t      state;
    logic [PAGE_AW-1:0] ptr;
    logic [PAGE_DW-1:0] sum;
    logic [PAGE_DW-1:0] remain;
    logic [8:0]         cnt;
    logic               accept;
    logic               wr_en;
    logic [PAGE_DW-1:0] csum_total;

    assign accept     = in_valid && in_ready;
    assign wr_en      = accept && (state == DATA);
    assign csum_total = sum + in_data;
    assign busy       = (state != IDLE);

    page_ram u_ram (
        .clk     (hw_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (ptr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Frame parser: advances on accepted bytes, DONE lasts one cycle with ready dropped
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sum       <= '0;
            remain    <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            wr_count  <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            in_ready  <= 1'b1;
            case (state)
                IDLE: if (accept && in_data == SYNC_BYTE) state <= ADDR;
                ADDR: if (accept) begin
                    ptr   <= in_data;
                    sum   <= in_data;
                    state <= LEN;
                end
                LEN: if (accept) begin
                    remain <= in_data;
                    sum    <= csum_total;
                    cnt    <= '0;
                    state  <= DATA;
                end
                DATA: if (accept) begin
                    ptr <= ptr + 8'd1;
                    sum <= csum_total;
                    cnt <= cnt + 9'd1;
                    if (remain == 8'd0) state <= CSUM;
                    else                remain <= remain - 8'd1;
                end
                CSUM: if (accept) begin
                    frame_ok  <= (csum_total == 8'd0);
                    frame_err <= (csum_total != 8'd0);
                    in_ready  <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    wr_count <= cnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_page_param_loader.sv
// tb_page_param_loader: randomized frames checked against a byte-array page model
module tb_page_param_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic       hw_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [8:0] wr_count;

    int checks = 0;
    int passed = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int bad_nr = 0;
    bit live = 1'b0;

    logic [7:0] ref_ram [256];
    bit         known   [256];

    page_param_loader #(.SYNC_BYTE(SYNC)) dut (
        .hw_clk    (hw_clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .wr_count  (wr_count)
    );

    always #5 hw_clk = ~hw_clk;

    // live: at least one edge has passed since reset release
    always @(posedge hw_clk or negedge rst_n) live <= rst_n;

    // pulse counters and ready-low outside the result cycle
    always @(negedge hw_clk) begin
        if (frame_ok) ok_cnt <= ok_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (live && rst_n && !in_ready && !frame_ok && !frame_err) bad_nr <= bad_nr + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge hw_clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge hw_clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
        end
        @(posedge hw_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge hw_clk);
    endtask

    // gap: 0 full rate, 1 one idle cycle before each payload byte, 2 random 0..2
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] data[$], input bit good,
                              input int gap, input string tag);
        logic [7:0] s, a, c, old;
        int n, ok0, err0;
        n    = data.size();
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(SYNC);
        send_byte(addr);
        send_byte(8'(n - 1));
        s = addr + 8'(n - 1);
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            if (gap == 1) idle(1);
            else if (gap == 2) idle($urandom_range(0, 2));
            old = ref_ram[a];
            send_byte(data[i]);
            if (rd_addr == a && known[a]) begin
                checks++;
                if (rd_data !== old) $display("FAIL %s rbw addr=%h got %h required %h", tag, a, rd_data, old);
                else passed++;
            end
            ref_ram[a] = data[i];
            known[a]   = 1'b1;
            s += data[i];
        end
        c = 8'h00 - s;
        if (!good) c = c + 8'd1;
        send_byte(c);
        @(negedge hw_clk);
        checks++;
        if ({frame_ok, frame_err, in_ready, busy} !== {good, !good, 1'b0, 1'b1})
            $display("FAIL %s done_cycle ok/err/rdy/busy got %b%b%b%b required %b%b01", tag,
                     frame_ok, frame_err, in_ready, busy, good, !good);
        else passed++;
        @(negedge hw_clk);
        checks++;
        if ({busy, frame_ok, frame_err} !== 3'b000)
            $display("FAIL %s after_done busy/ok/err got %b%b%b required 000", tag, busy, frame_ok, frame_err);
        else passed++;
        checks++;
        if (wr_count !== 9'(n)) $display("FAIL %s wr_count got %0d required %0d", tag, wr_count, n);
        else passed++;
        checks++;
        if ((ok_cnt - ok0) !== int'(good) || (err_cnt - err0) !== int'(!good))
            $display("FAIL %s pulse_count ok=%0d err=%0d required ok=%0d err=%0d", tag,
                     ok_cnt - ok0, err_cnt - err0, int'(good), int'(!good));
        else passed++;
    endtask

    task automatic check_ram(input logic [7:0] a, input string tag);
        @(negedge hw_clk);
        rd_addr = a;
        @(negedge hw_clk);
        checks++;
        if (rd_data !== ref_ram[a]) $display("FAIL %s ram[%h] got %h required %h", tag, a, rd_data, ref_ram[a]);
        else passed++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, busy, frame_ok, frame_err, wr_count, rd_data} !== 21'd0)
            $display("FAIL reset_outputs got rdy=%b busy=%b ok=%b err=%b wc=%0d rd=%h required all 0",
                     in_ready, busy, frame_ok, frame_err, wr_count, rd_data);
        else passed++;
        @(posedge hw_clk);
        #1 rst_n = 1'b1;
        @(negedge hw_clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_release_ready got %b required 0", in_ready);
        else passed++;
        @(negedge hw_clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL ready_after_edge got rdy=%b busy=%b required 1 0", in_ready, busy);
        else passed++;
    endtask

    task automatic test_basic();
        send_frame(8'h03, '{8'h11, 8'h22}, 1'b1, 0, "basic");
        check_ram(8'h03, "basic");
        check_ram(8'h04, "basic");
        send_frame(8'h03, '{8'h11, 8'h22}, 1'b0, 0, "bad_csum");
        check_ram(8'h03, "bad_csum");
        check_ram(8'h04, "bad_csum");
    endtask

    task automatic test_wrap();
        send_frame(8'hFE, '{8'h01, 8'h02, 8'h03}, 1'b1, 0, "wrap");
        check_ram(8'hFE, "wrap");
        check_ram(8'hFF, "wrap");
        check_ram(8'h00, "wrap");
    endtask

    task automatic test_stray();
        send_byte(8'h00);
        @(negedge hw_clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL stray_00 busy got %b required 0", busy);
        else passed++;
        send_byte(8'hFF);
        @(negedge hw_clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL stray_ff busy got %b required 0", busy);
        else passed++;
        send_frame(8'h20, '{8'hA5, 8'h5A}, 1'b1, 0, "after_stray");
        check_ram(8'h20, "after_stray");
        check_ram(8'h21, "after_stray");
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        send_frame(8'h60, q, 1'b1, 0, "full_rate");
        send_frame(8'h70, q, 1'b1, 1, "toggled");
        for (int i = 0; i < 6; i++) check_ram(8'h70 + 8'(i), "toggled");
    endtask

    task automatic test_rbw();
        rd_addr = 8'h61;
        @(negedge hw_clk);
        send_frame(8'h61, '{8'($urandom), 8'($urandom)}, 1'b1, 0, "rbw");
        check_ram(8'h61, "rbw");
    endtask

    task automatic test_reset_mid_frame();
        int ok0, err0;
        ok0 = ok_cnt;
        err0 = err_cnt;
        send_byte(SYNC);
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h5C);
        ref_ram[8'h40] = 8'h5C;
        known[8'h40]   = 1'b1;
        @(negedge hw_clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, frame_ok, frame_err} !== 4'b0000)
            $display("FAIL mid_reset rdy/busy/ok/err got %b%b%b%b required 0000", in_ready, busy, frame_ok, frame_err);
        else passed++;
        repeat (2) @(posedge hw_clk);
        #1 rst_n = 1'b1;
        check_ram(8'h40, "mid_reset");
        checks++;
        if (ok_cnt != ok0 || err_cnt != err0 || busy !== 1'b0)
            $display("FAIL mid_reset_pulse ok=%0d err=%0d busy=%b required 0 0 0", ok_cnt - ok0, err_cnt - err0, busy);
        else passed++;
        send_frame(8'h41, '{8'h01, 8'h02, 8'h03}, 1'b1, 0, "post_reset");
        check_ram(8'h40, "post_reset");
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int n;
        for (int f = 0; f < 8; f++) begin
            q.delete();
            n = (f == 3) ? 256 : $urandom_range(1, 12);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send_frame(8'($urandom), q, 1'($urandom), $urandom_range(0, 2), $sformatf("rand%0d", f));
        end
        for (int a = 0; a < 256; a++)
            if (known[a] && ($urandom_range(0, 3) == 0)) check_ram(8'(a), "rand_ram");
    endtask

    initial begin
        for (int a = 0; a < 256; a++) known[a] = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stray();
        test_backpressure();
        test_rbw();
        test_reset_mid_frame();
        test_random();
        @(negedge hw_clk);
        checks++;
        if (bad_nr !== 0) $display("FAIL ready_low_outside_done count got %0d required 0", bad_nr);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
